// File: rtl/spi_slave_rx.sv
// SPI mode-0 target receiver: synchronises the SPI pins into clk, deframes command + payload bytes.
// Optional MISO return path is compiled in with `define SPI_SLAVE_MISO_EN.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_ssel_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [7:0]  spi_txdata,
    output logic        spi_tx_next,
    output logic [7:0]  spi_cmd,
    output logic [63:0] spi_rxdata,
    output logic [3:0]  spi_rxcount,
    output logic        spi_msg_end
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_CMD   = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    localparam logic [7:0] IDLE_OBS = 8'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ssel_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   ssel_prev_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [63:0] rxdata_q, rxdata_d;
    logic [3:0]  rxcount_q, rxcount_d;
    logic        msg_end_q, msg_end_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;

    logic        sck_s, ssel_s, mosi_s;
    logic        sck_rise_s, ssel_rise_s, ssel_fall_s;
    logic [7:0]  byte_s;
    logic        in_frame_s;
    logic        bit_take_s;
    logic        byte_done_s;
    logic        frame_start_s;
    logic        frame_stop_s;

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign ssel_s      = ssel_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise_s  = sck_s & ~sck_prev_q;
    assign ssel_rise_s = ssel_s & ~ssel_prev_q;
    assign ssel_fall_s = ~ssel_s & ssel_prev_q;
    assign byte_s      = {rx_byte_q[6:0], mosi_s};

    assign in_frame_s    = (state_q == ST_CMD) || (state_q == ST_DATA);
    assign bit_take_s    = in_frame_s && sck_rise_s && !ssel_rise_s;
    assign byte_done_s   = bit_take_s && (bit_cnt_q == 3'd7);
    assign frame_start_s = (state_q == ST_READY) && ssel_fall_s;
    assign frame_stop_s  = in_frame_s && ssel_rise_s;

    // Pin synchronisers and edge-detect history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= {SYNC_STAGES{1'b1}};
            ssel_sync_q <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b1}};
            sck_prev_q  <= 1'b1;
            ssel_prev_q <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], spi_ssel_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            ssel_prev_q <= ssel_s;
        end
    end

    // Deframing state machine: next state and next register values.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_byte_d  = rx_byte_q;
        cmd_d      = cmd_q;
        rxdata_d   = rxdata_q;
        rxcount_d  = rxcount_q;
        msg_end_d  = 1'b0;
        idle_cnt_d = 8'd0;
        case (state_q)
            // After reset the synchroniser still holds its reset 1s, so ssel
            // must be seen high once more than the chain is deep before it is trusted.
            ST_IDLE: begin
                if (ssel_s) begin
                    if (idle_cnt_q >= IDLE_OBS) begin
                        state_d = ST_READY;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end else begin
                    idle_cnt_d = 8'd0;
                end
            end
            ST_READY: begin
                if (ssel_fall_s) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd0;
                    rx_byte_d = 8'h00;
                    rxdata_d  = 64'd0;
                    rxcount_d = 4'd0;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_CMD: begin
                if (ssel_rise_s) begin
                    state_d = ST_READY;
                end else if (sck_rise_s) begin
                    rx_byte_d = byte_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        cmd_d   = byte_s;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                if (ssel_rise_s) begin
                    state_d   = ST_READY;
                    msg_end_d = 1'b1;
                end else if (sck_rise_s) begin
                    rx_byte_d = byte_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rxdata_d  = {byte_s, rxdata_q[63:8]};
                        rxcount_d = (rxcount_q == 4'd15) ? 4'd15 : (rxcount_q + 4'd1);
                    end else begin
                        rxcount_d = rxcount_q;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Deframing state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_byte_q  <= 8'h00;
            cmd_q      <= 8'h00;
            rxdata_q   <= 64'd0;
            rxcount_q  <= 4'd0;
            msg_end_q  <= 1'b0;
            idle_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_byte_q  <= rx_byte_d;
            cmd_q      <= cmd_d;
            rxdata_q   <= rxdata_d;
            rxcount_q  <= rxcount_d;
            msg_end_q  <= msg_end_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign spi_cmd     = cmd_q;
    assign spi_rxdata  = rxdata_q;
    assign spi_rxcount = rxcount_q;
    assign spi_msg_end = msg_end_q;

`ifdef SPI_SLAVE_MISO_EN
    logic       sck_fall_s;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_pend_q, tx_pend_d;
    logic       tx_next_q, tx_next_d;

    assign sck_fall_s = ~sck_s & sck_prev_q;

    // TX shifter; a byte-boundary reload waits for the following SCK fall so the
    // new MSB is not shifted away before the host samples it.
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_pend_d  = tx_pend_q;
        tx_next_d  = 1'b0;
        if (frame_start_s) begin
            tx_shift_d = spi_txdata;
            tx_pend_d  = 1'b0;
            tx_next_d  = 1'b1;
        end else if (!in_frame_s || frame_stop_s) begin
            tx_shift_d = 8'hFF;
            tx_pend_d  = 1'b0;
        end else if (sck_fall_s) begin
            if (tx_pend_q) begin
                tx_shift_d = spi_txdata;
                tx_pend_d  = 1'b0;
                tx_next_d  = 1'b1;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end
        end else if (byte_done_s) begin
            tx_pend_d = 1'b1;
        end else begin
            tx_pend_d = tx_pend_q;
        end
    end

    // TX shifter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift_q <= 8'hFF;
            tx_pend_q  <= 1'b0;
            tx_next_q  <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_pend_q  <= tx_pend_d;
            tx_next_q  <= tx_next_d;
        end
    end

    assign spi_miso    = tx_shift_q[7];
    assign spi_tx_next = tx_next_q;
`else
    logic unused_txdata_s;
    assign unused_txdata_s = ^{spi_txdata, byte_done_s, bit_take_s, frame_start_s, frame_stop_s};
    assign spi_miso        = 1'b1;
    assign spi_tx_next     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of SPI frames plus hand-written corner sequences.
module tb_spi_slave_rx;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic        spi_ssel_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  spi_txdata;
    logic        spi_tx_next;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;
    logic [3:0]  spi_rxcount;
    logic        spi_msg_end;

    spi_slave_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_ssel_n  (spi_ssel_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_txdata  (spi_txdata),
        .spi_tx_next (spi_tx_next),
        .spi_cmd     (spi_cmd),
        .spi_rxdata  (spi_rxdata),
        .spi_rxcount (spi_rxcount),
        .spi_msg_end (spi_msg_end)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   end_pulses = 0;
    int   end_cycles = 0;
    int   tx_pulses = 0;
    logic end_prev = 1'b0;

    // Count msg_end pulses and high cycles, and tx_next pulses.
    always @(posedge clk) begin
        end_prev <= (spi_msg_end === 1'b1);
        if (spi_msg_end === 1'b1) end_cycles <= end_cycles + 1;
        if (spi_msg_end === 1'b1 && !end_prev) end_pulses <= end_pulses + 1;
        if (spi_tx_next === 1'b1) tx_pulses <= tx_pulses + 1;
    end

    typedef struct {
        logic [7:0]   cmd;
        int           cmd_bits;
        int           nbytes;
        logic [127:0] pl;
        int           extra;
        int           exp_end;
        logic [7:0]   exp_cmd;
        logic [63:0]  exp_data;
        logic [3:0]   exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(HALF);
        m = spi_miso;
        spi_sck = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] rd);
        logic m;
        for (int i = 0; i < 8; i++) begin
            send_bit(b[7-i], m);
            rd[7-i] = m;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   p0;
        int   c0;
        logic m;
        p0 = end_pulses;
        c0 = end_cycles;
        wait_clk(6);
        spi_ssel_n = 1'b0;
        wait_clk(2 * HALF);
        for (int i = 0; i < v.cmd_bits; i++) send_bit(v.cmd[7-i], m);
        for (int k = 0; k < v.nbytes; k++)
            for (int i = 0; i < 8; i++) send_bit(v.pl[8*k+7-i], m);
        for (int i = 0; i < v.extra; i++) send_bit(1'b1, m);
        wait_clk(HALF);
        spi_ssel_n = 1'b1;
        wait_clk(8);
        chk({tag, "_pulses"}, 64'(end_pulses - p0), 64'(v.exp_end));
        chk({tag, "_width"},  64'(end_cycles - c0), 64'(v.exp_end));
        chk({tag, "_cmd"},    64'(spi_cmd), 64'(v.exp_cmd));
        chk({tag, "_rxdata"}, spi_rxdata, v.exp_data);
        chk({tag, "_rxcount"}, 64'(spi_rxcount), 64'(v.exp_cnt));
    endtask

    initial begin
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic       m;
        int         p0;
        int         t0;
        vec_t       hv;

        vecs[0] = '{8'h02, 8, 1,  128'h01, 0, 1, 8'h02, 64'h0100000000000000, 4'd1};
        vecs[1] = '{8'h10, 8, 8,  128'h0807060504030201, 0, 1, 8'h10, 64'h0807060504030201, 4'd8};
        vecs[2] = '{8'h11, 8, 2,  128'h5AA5, 0, 1, 8'h11, 64'h5AA5000000000000, 4'd2};
        vecs[3] = '{8'h11, 8, 10, 128'h0A090807060504030201, 0, 1, 8'h11, 64'h0A09080706050403, 4'd10};
        vecs[4] = '{8'hFF, 5, 0,  128'h0, 0, 0, 8'h11, 64'h0, 4'd0};
        vecs[5] = '{8'h02, 8, 0,  128'h0, 3, 1, 8'h02, 64'h0, 4'd0};
        vecs[6] = '{8'h20, 8, 0,  128'h0, 0, 1, 8'h20, 64'h0, 4'd0};
        vecs[7] = '{8'h33, 8, 16, 128'h100F0E0D0C0B0A090807060504030201, 0, 1, 8'h33,
                    64'h100F0E0D0C0B0A09, 4'd15};

        // Reset with a frame in progress and SCK toggling.
        reset      = 1'b1;
        spi_ssel_n = 1'b0;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        spi_txdata = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1 spi_sck = ~spi_sck;
        end
        chk("rst_cmd",     64'(spi_cmd), 64'h0);
        chk("rst_rxdata",  spi_rxdata, 64'h0);
        chk("rst_rxcount", 64'(spi_rxcount), 64'h0);
        chk("rst_msg_end", 64'(spi_msg_end), 64'h0);
        chk("rst_miso",    64'(spi_miso), 64'h1);
        chk("rst_tx_next", 64'(spi_tx_next), 64'h0);
        reset   = 1'b0;
        spi_sck = 1'b0;
        wait_clk(1);
        p0 = end_pulses;
        send_byte(8'h02, rd1);
        send_byte(8'h01, rd1);
        wait_clk(HALF);
        spi_ssel_n = 1'b1;
        wait_clk(10);
        chk("rst_frame_no_end", 64'(end_pulses - p0), 64'h0);

        for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // SCK edges while deselected must not shift into the next frame.
        for (int i = 0; i < 5; i++) send_bit(1'b1, m);
        hv = '{8'h55, 8, 1, 128'h66, 0, 1, 8'h55, 64'h6600000000000000, 4'd1};
        run_vec(hv, "desel_sck");

        // Deselect and the final SCK rise arrive together: the bit is dropped.
        p0 = end_pulses;
        wait_clk(6);
        spi_ssel_n = 1'b0;
        wait_clk(2 * HALF);
        send_byte(8'h44, rd1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, m);
        spi_mosi = 1'b1;
        wait_clk(HALF);
        spi_sck    = 1'b1;
        spi_ssel_n = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b0;
        wait_clk(6);
        chk("tie_pulses",  64'(end_pulses - p0), 64'h1);
        chk("tie_cmd",     64'(spi_cmd), 64'h44);
        chk("tie_rxcount", 64'(spi_rxcount), 64'h0);
        chk("tie_rxdata",  spi_rxdata, 64'h0);

        // msg_end appears exactly SYNC_STAGES+1 cycles after the ssel pin rise.
        wait_clk(6);
        spi_ssel_n = 1'b0;
        wait_clk(2 * HALF);
        send_byte(8'h5A, rd1);
        send_byte(8'h77, rd1);
        wait_clk(HALF);
        spi_ssel_n = 1'b1;
        wait_clk(2);
        chk("lat_early", 64'(spi_msg_end), 64'h0);
        wait_clk(1);
        chk("lat_pulse", 64'(spi_msg_end), 64'h1);
        wait_clk(1);
        chk("lat_after", 64'(spi_msg_end), 64'h0);
        chk("lat_rxdata", spi_rxdata, 64'h7700000000000000);

`ifdef SPI_SLAVE_MISO_EN
        spi_txdata = 8'hC3;
        wait_clk(6);
        t0 = tx_pulses;
        spi_ssel_n = 1'b0;
        wait_clk(2 * HALF);
        chk("tx_next_fall", 64'(tx_pulses - t0), 64'h1);
        spi_txdata = 8'h3C;
        send_byte(8'h02, rd1);
        wait_clk(HALF);
        chk("tx_next_byte1", 64'(tx_pulses - t0), 64'h2);
        send_byte(8'h01, rd2);
        wait_clk(HALF);
        spi_ssel_n = 1'b1;
        wait_clk(8);
        chk("miso_byte0", 64'(rd1), 64'hC3);
        chk("miso_byte1", 64'(rd2), 64'h3C);
        chk("miso_desel", 64'(spi_miso), 64'h1);
`else
        t0 = 0;
        chk("miso_idle_high", 64'(spi_miso), 64'h1);
        chk("tx_next_never", 64'(tx_pulses - t0), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
